// File: rtl/instr_exec_unit.sv
// instr_exec_unit
// ---------------
// Fetch/decode/execute stage for the 16-bit instruction-memory datapath.
// Each instruction takes three cycles:
//   FETCH  -> DECODE -> EXEC
// The program counter can branch, so it replaces a free-running address counter.
// Instructions run against an internal 16x16 register file.
// Every register write-back is reported, and a HALT instruction parks the unit
// until the next reset.
//
// Ports:
//   clk        in   1   system clock, rising-edge
//   rst_n      in   1   asynchronous active-low reset
//   run        in   1   1 = proceed, 0 = stall at the next FETCH
//   instr_in   in  16   instruction word at address pc_out
//   dbg_addr   in   4   register-file debug read address
//   pc_out     out  4   instruction address to the storage block
//   read       out  1   storage read strobe, high while in FETCH
//   wb_valid   out  1   one-cycle pulse after a register write
//   wb_addr    out  4   register written
//   wb_data    out 16   value written
//   zero_flag  out  1   last ALU write-back result was zero
//   halted     out  1   HALT has executed
//   dbg_data   out 16   combinational read of reg[dbg_addr]

module instr_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] instr_in,
  input  logic [3:0]  dbg_addr,
  output logic [3:0]  pc_out,
  output logic        read,
  output logic        wb_valid,
  output logic [3:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        zero_flag,
  output logic        halted,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [3:0]  pc;
  logic [15:0] ir;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] rf [16];

  logic [3:0]  op;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic [7:0]  imm8;
  logic [3:0]  imm4;

  logic [15:0] result;
  logic        is_wb;
  logic [3:0]  pc_next;

  // Instruction fields are sliced from the latched word.
  // The imm4 field doubles as the jump/branch target.
  assign op   = ir[15:12];
  assign rd   = ir[11:8];
  assign rs   = ir[7:4];
  assign rt   = ir[3:0];
  assign imm8 = ir[7:0];
  assign imm4 = ir[3:0];

  assign pc_out   = pc;
  assign dbg_data = rf[dbg_addr];

  // State register.
  // Reset always returns to FETCH, which drops any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and read strobe.
  // A low run is only honoured in FETCH, so an instruction already past
  // FETCH always completes. HALT is terminal until reset.
  always_comb begin
    state_next = state;
    read       = 1'b0;
    case (state)
      S_FETCH: begin
        read = 1'b1;
        if (run) begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = (op == 4'hF) ? S_HALT : S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  // ALU and write-back qualification.
  // Opcodes 1..B write reg[rd] and update zero_flag.
  // Everything else leaves the register file and the flag alone.
  always_comb begin
    result = 16'h0000;
    is_wb  = 1'b0;
    case (op)
      4'h1: begin result = a + b;              is_wb = 1'b1; end
      4'h2: begin result = a - b;              is_wb = 1'b1; end
      4'h3: begin result = a & b;              is_wb = 1'b1; end
      4'h4: begin result = a | b;              is_wb = 1'b1; end
      4'h5: begin result = a ^ b;              is_wb = 1'b1; end
      4'h6: begin result = ~a;                 is_wb = 1'b1; end
      4'h7: begin result = a << imm4;          is_wb = 1'b1; end
      4'h8: begin result = a >> imm4;          is_wb = 1'b1; end
      4'h9: begin result = {8'h00, imm8};      is_wb = 1'b1; end
      4'hA: begin result = a + {12'h000, imm4}; is_wb = 1'b1; end
      4'hB: begin result = a;                  is_wb = 1'b1; end
      default: begin
        result = 16'h0000;
        is_wb  = 1'b0;
      end
    endcase
  end

  // Program-counter update applied at the EXEC edge.
  // Branches test the flag from earlier write-backs.
  // HALT holds pc, so pc_out keeps pointing at the HALT word.
  always_comb begin
    pc_next = pc + 4'd1;
    case (op)
      4'hC: pc_next = imm4;
      4'hD: pc_next = zero_flag ? imm4 : pc + 4'd1;
      4'hE: pc_next = zero_flag ? pc + 4'd1 : imm4;
      4'hF: pc_next = pc;
      default: pc_next = pc + 4'd1;
    endcase
  end

  // Datapath registers.
  // Operands are captured in DECODE, so an instruction whose rd equals
  // rs or rt still computes with the old values.
  // wb_valid is cleared every cycle other than the one after a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= 4'd0;
      ir        <= 16'h0000;
      a         <= 16'h0000;
      b         <= 16'h0000;
      zero_flag <= 1'b0;
      wb_valid  <= 1'b0;
      wb_addr   <= 4'd0;
      wb_data   <= 16'h0000;
      halted    <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        rf[i] <= 16'h0000;
      end
    end else begin
      wb_valid <= 1'b0;
      case (state)
        S_FETCH: begin
          if (run) begin
            ir <= instr_in;
          end
        end
        S_DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
        end
        S_EXEC: begin
          pc <= pc_next;
          if (is_wb) begin
            rf[rd]    <= result;
            zero_flag <= (result == 16'h0000);
            wb_valid  <= 1'b1;
            wb_addr   <= rd;
            wb_data   <= result;
          end
          if (op == 4'hF) begin
            halted <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Testbench for instr_exec_unit.
//
// The bench models the storage block as a 16-word array indexed by pc_out.
// A table of short programs is run from reset. After each program, the bench
// checks one register, zero_flag and the next pc against hand-computed values.
// Hand-written sequences then cover:
//   - write-back timing
//   - reset mid-instruction
//   - pc wrap
//   - stall
//   - halt

module tb_instr_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] instr_in;
  logic [3:0]  dbg_addr;
  logic [3:0]  pc_out;
  logic        read;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        zero_flag;
  logic        halted;
  logic [15:0] dbg_data;

  logic [15:0] imem [16];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string           name;
    logic [3:0][15:0] prog;
    int              n;
    logic [3:0]      reg_addr;
    logic [15:0]     reg_val;
    logic            zf;
    logic [3:0]      pc;
  } vec_t;

  vec_t vecs [18];

  instr_exec_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .instr_in  (instr_in),
    .dbg_addr  (dbg_addr),
    .pc_out    (pc_out),
    .read      (read),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .zero_flag (zero_flag),
    .halted    (halted),
    .dbg_data  (dbg_data)
  );

  // Storage block model: the word at pc_out is presented combinationally.
  assign instr_in = imem[pc_out];

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read a register through the debug port and compare it.
  task automatic checkReg(input string name, input logic [3:0] r, input logic [15:0] exp);
    dbg_addr = r;
    #1;
    checkOutput(name, dbg_data, exp);
  endtask

  task automatic fillMem(input logic [15:0] w);
    for (int i = 0; i < 16; i++) imem[i] = w;
  endtask

  // Hold reset over two falling edges, then release on a falling edge.
  // The next rising edge ends the first FETCH.
  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  // Load a table program (HALT everywhere else).
  // Run it for exactly n instructions, leaving the unit in the next FETCH.
  task automatic applyStimulus(input vec_t v);
    fillMem(16'hF000);
    for (int i = 0; i < v.n; i++) imem[i] = v.prog[i];
    run = 1'b1;
    resetDut();
    stepCycles(3 * v.n);
  endtask

  task automatic setVec(input int idx, input string name,
                        input logic [15:0] p0, input logic [15:0] p1,
                        input logic [15:0] p2, input logic [15:0] p3,
                        input int n, input logic [3:0] ra, input logic [15:0] rv,
                        input logic zf, input logic [3:0] pc);
    vecs[idx].name     = name;
    vecs[idx].prog[0]  = p0;
    vecs[idx].prog[1]  = p1;
    vecs[idx].prog[2]  = p2;
    vecs[idx].prog[3]  = p3;
    vecs[idx].n        = n;
    vecs[idx].reg_addr = ra;
    vecs[idx].reg_val  = rv;
    vecs[idx].zf       = zf;
    vecs[idx].pc       = pc;
  endtask

  initial begin
    int wb_cycles [4];
    int wb_seen;
    int bad;
    logic [3:0]  exp_addr [4];
    logic [15:0] exp_data [4];

    rst_n    = 1'b0;
    run      = 1'b0;
    dbg_addr = 4'd0;
    fillMem(16'h0000);

    setVec( 0, "arith",    16'h9105, 16'h9203, 16'h1312, 16'h2421, 4, 4'd4, 16'hFFFE, 1'b0, 4'h4);
    setVec( 1, "bz_taken", 16'h9100, 16'h2511, 16'hD00A, 16'h0000, 3, 4'd5, 16'h0000, 1'b1, 4'hA);
    setVec( 2, "bnz_fall", 16'h9100, 16'h2511, 16'hE00A, 16'h0000, 3, 4'd5, 16'h0000, 1'b1, 4'h3);
    setVec( 3, "shl",      16'h91FF, 16'h7214, 16'h0000, 16'h0000, 2, 4'd2, 16'h0FF0, 1'b0, 4'h2);
    setVec( 4, "shr",      16'h91FF, 16'h7214, 16'h8224, 16'h0000, 3, 4'd2, 16'h00FF, 1'b0, 4'h3);
    setVec( 5, "not",      16'h9100, 16'h6210, 16'h0000, 16'h0000, 2, 4'd2, 16'hFFFF, 1'b0, 4'h2);
    setVec( 6, "and",      16'h910C, 16'h920A, 16'h3312, 16'h0000, 3, 4'd3, 16'h0008, 1'b0, 4'h3);
    setVec( 7, "or",       16'h910C, 16'h920A, 16'h4312, 16'h0000, 3, 4'd3, 16'h000E, 1'b0, 4'h3);
    setVec( 8, "xor",      16'h910C, 16'h920A, 16'h5312, 16'h0000, 3, 4'd3, 16'h0006, 1'b0, 4'h3);
    setVec( 9, "xor_self", 16'h910C, 16'h5311, 16'h0000, 16'h0000, 2, 4'd3, 16'h0000, 1'b1, 4'h2);
    setVec(10, "addi",     16'h91FF, 16'hA11F, 16'h0000, 16'h0000, 2, 4'd1, 16'h010E, 1'b0, 4'h2);
    setVec(11, "mov",      16'h9142, 16'hB210, 16'h0000, 16'h0000, 2, 4'd2, 16'h0042, 1'b0, 4'h2);
    setVec(12, "jmp",      16'hC007, 16'h0000, 16'h0000, 16'h0000, 1, 4'd0, 16'h0000, 1'b0, 4'h7);
    setVec(13, "nop_zf",   16'h9100, 16'h0000, 16'h0000, 16'h0000, 2, 4'd1, 16'h0000, 1'b1, 4'h2);
    setVec(14, "shift0",   16'h91AB, 16'h7210, 16'h0000, 16'h0000, 2, 4'd2, 16'h00AB, 1'b0, 4'h2);
    setVec(15, "rd_eq_rs", 16'h9103, 16'h1111, 16'h0000, 16'h0000, 2, 4'd1, 16'h0006, 1'b0, 4'h2);
    setVec(16, "bz_fall",  16'h9101, 16'hD00A, 16'h0000, 16'h0000, 2, 4'd1, 16'h0001, 1'b0, 4'h2);
    setVec(17, "bnz_take", 16'h9101, 16'hE00A, 16'h0000, 16'h0000, 2, 4'd1, 16'h0001, 1'b0, 4'hA);

    // Table-driven programs.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkReg({vecs[i].name, "_reg"}, vecs[i].reg_addr, vecs[i].reg_val);
      checkOutput({vecs[i].name, "_zf"}, {15'd0, zero_flag}, {15'd0, vecs[i].zf});
      checkOutput({vecs[i].name, "_pc"}, {12'd0, pc_out}, {12'd0, vecs[i].pc});
    end

    // Write-back order and timing for the arithmetic program.
    // Pulses are expected on cycles 3, 6, 9 and 12 after reset release.
    exp_addr = '{4'd1, 4'd2, 4'd3, 4'd4};
    exp_data = '{16'h0005, 16'h0003, 16'h0008, 16'hFFFE};
    fillMem(16'hF000);
    imem[0] = 16'h9105; imem[1] = 16'h9203; imem[2] = 16'h1312; imem[3] = 16'h2421;
    run = 1'b1;
    resetDut();
    checkOutput("reset_pc", {12'd0, pc_out}, 16'h0000);
    checkOutput("reset_read", {15'd0, read}, 16'h0001);
    wb_seen = 0;
    for (int c = 1; c <= 13; c++) begin
      stepCycles(1);
      if (wb_valid) begin
        if (wb_seen < 4) begin
          wb_cycles[wb_seen] = c;
          checkOutput($sformatf("wb%0d_addr", wb_seen), {12'd0, wb_addr}, {12'd0, exp_addr[wb_seen]});
          checkOutput($sformatf("wb%0d_data", wb_seen), wb_data, exp_data[wb_seen]);
        end
        wb_seen++;
      end
    end
    checkOutput("wb_count", wb_seen[15:0], 16'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < wb_seen) begin
        checkOutput($sformatf("wb%0d_cycle", k), wb_cycles[k][15:0], 16'(3 * (k + 1)));
      end
    end
    checkOutput("arith_zf", {15'd0, zero_flag}, 16'h0000);

    // Reset asserted during EXEC of the ADD (cycle 8).
    // Nothing from it must land.
    resetDut();
    stepCycles(8);
    rst_n = 1'b0;
    #2;
    checkOutput("rst_pc", {12'd0, pc_out}, 16'h0000);
    checkOutput("rst_halted", {15'd0, halted}, 16'h0000);
    checkOutput("rst_wb_valid", {15'd0, wb_valid}, 16'h0000);
    checkOutput("rst_zf", {15'd0, zero_flag}, 16'h0000);
    bad = 0;
    for (int r = 0; r < 16; r++) begin
      dbg_addr = r[3:0];
      #1;
      if (dbg_data !== 16'h0000) bad++;
    end
    checkOutput("rst_regs_nonzero", bad[15:0], 16'd0);

    // pc wrap: jump to 15, LDI there, next address must be 0.
    fillMem(16'hF000);
    imem[0] = 16'hC00F; imem[15] = 16'h91FF;
    run = 1'b1;
    resetDut();
    stepCycles(6);
    checkOutput("wrap_wb_valid", {15'd0, wb_valid}, 16'h0001);
    checkReg("wrap_r1", 4'd1, 16'h00FF);
    checkOutput("wrap_pc", {12'd0, pc_out}, 16'h0000);

    // Stall: run drops during DECODE of 9107.
    // The LDI still completes, then the FSM holds in FETCH at pc 1.
    fillMem(16'hF000);
    imem[0] = 16'h9107; imem[1] = 16'h9202;
    run = 1'b1;
    resetDut();
    stepCycles(1);
    run = 1'b0;
    stepCycles(2);
    checkOutput("stall_wb_valid", {15'd0, wb_valid}, 16'h0001);
    checkReg("stall_r1", 4'd1, 16'h0007);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      stepCycles(1);
      if (wb_valid !== 1'b0 || pc_out !== 4'd1 || read !== 1'b1) bad++;
    end
    checkOutput("stall_hold_viol", bad[15:0], 16'd0);
    @(negedge clk);
    run = 1'b1;
    stepCycles(3);
    checkOutput("resume_wb_addr", {15'd0, wb_valid, wb_addr}, 16'h0012);
    checkOutput("resume_wb_data", wb_data, 16'h0002);
    checkOutput("resume_pc", {12'd0, pc_out}, 16'h0002);

    // Halt at pc 4 after four NOPs.
    fillMem(16'h0000);
    imem[4] = 16'hF000;
    run = 1'b1;
    resetDut();
    stepCycles(14);
    checkOutput("halt_before", {15'd0, halted}, 16'h0000);
    stepCycles(1);
    checkOutput("halt_after", {15'd0, halted}, 16'h0001);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (pc_out !== 4'd4 || read !== 1'b0 || wb_valid !== 1'b0 || halted !== 1'b1) bad++;
      stepCycles(1);
    end
    checkOutput("halt_hold_viol", bad[15:0], 16'd0);
    resetDut();
    checkOutput("restart_pc", {12'd0, pc_out}, 16'h0000);
    checkOutput("restart_halted", {15'd0, halted}, 16'h0000);
    stepCycles(3);
    checkOutput("restart_next_pc", {12'd0, pc_out}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
